dft_32to16_seq: RTL and testbench

//  Streaming sequencer for the 32-point radix-2 first stage. It accepts one real sample per cycle
//  (valid/ready) and stores x0..x15 in a half-frame buffer. As each sample x(k+16) arrives, it drives
//  one shared butterfly instance with the pair (x(k), x(k+16)).
//  It emits the pair fa(k)=x(k)+x(k+16) and fb(k)=x(k)-x(k+16), tagged with index k, to the

---
 rtl/fft_pkg.sv | 22 ++
 rtl/but_32.sv | 29 ++
 rtl/dft_32to16_seq.sv | 183 ++++++++++++++++++
 tb/tb_dft_32to16_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
// Module : fft_pkg
// Brief  : Shared defaults and state encoding for the radix-2 first-stage sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_DW = 8;
  localparam int FFT_N  = 32;
  localparam int FFT_KW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAIR = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/but_32.sv
// ============================================================================
// Module : but_32
// Brief  : Radix-2 butterfly; sign-extended exact sum and difference, no rounding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module but_32 #(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW:0]   sum,
  output logic signed [DW:0]   diff
);

  logic signed [DW:0] a_ext;
  logic signed [DW:0] b_ext;

  always_comb begin
    a_ext = {a[DW-1], a};
    b_ext = {b[DW-1], b};
    sum   = a_ext + b_ext;
    diff  = a_ext - b_ext;
  end

endmodule

`default_nettype wire

// File: rtl/dft_32to16_seq.sv
// ============================================================================
// Module : dft_32to16_seq
// Brief  : Streams a frame through one time-shared butterfly, pairing x(k) with x(k+H).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dft_32to16_seq
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int N  = FFT_N,
  parameter int KW = FFT_KW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW:0]   out_fa,
  output logic signed [DW:0]   out_fb,
  output logic [KW-1:0]        out_k,
  output logic                 out_last,
  output logic                 err_sop,
  input  logic                 err_clr
);

  localparam int          H        = N / 2;
  localparam logic [KW-1:0] K_LAST = KW'(H - 1);

  seq_state_e          state_q, state_d;
  logic [KW-1:0]       cnt_q, cnt_d;
  logic                err_sop_q, err_sop_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [KW-1:0]       out_k_q, out_k_d;
  logic signed [DW:0]  out_fa_q, out_fa_d;
  logic signed [DW:0]  out_fb_q, out_fb_d;

  logic signed [DW-1:0] mem_q [H];
  logic                 mem_we;
  logic [KW-1:0]        mem_wa;
  logic                 accept;
  logic                 pair_fire;
  logic                 err_set;
  logic signed [DW:0]   bf_sum;
  logic signed [DW:0]   bf_diff;

  assign accept = in_valid & in_ready;

  but_32 #(.DW(DW)) u_but (
    .a    (mem_q[cnt_q]),
    .b    (in_data),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any accepted in_sop restarts at x0; only in IDLE is that the expected case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            mem_we  = 1'b1;
            mem_wa  = '0;
            cnt_d   = KW'(1);
            state_d = ST_FILL;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_FILL, ST_PAIR: begin
        if (accept) begin
          if (in_sop) begin
            err_set = 1'b1;
            mem_we  = 1'b1;
            mem_wa  = '0;
            cnt_d   = KW'(1);
            state_d = ST_FILL;
          end else if (state_q == ST_FILL) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + KW'(1);
            if (cnt_q == K_LAST) begin
              cnt_d   = '0;
              state_d = ST_PAIR;
            end
          end else begin
            cnt_d = cnt_q + KW'(1);
            if (cnt_q == K_LAST) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    pair_fire = 1'b0;
    if (state_q == ST_PAIR) begin
      in_ready  = !out_valid_q || out_ready;
      pair_fire = accept && !in_sop;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= in_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_fa_d    = out_fa_q;
    out_fb_d    = out_fb_q;
    out_k_d     = out_k_q;
    out_last_d  = out_last_q;
    if (pair_fire) begin
      out_valid_d = 1'b1;
      out_fa_d    = bf_sum;
      out_fb_d    = bf_diff;
      out_k_d     = cnt_q;
      out_last_d  = (cnt_q == K_LAST);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    err_sop_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_sop_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_fa_q    <= '0;
      out_fb_q    <= '0;
      out_k_q     <= '0;
      out_last_q  <= 1'b0;
      err_sop_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_fa_q    <= out_fa_d;
      out_fb_q    <= out_fb_d;
      out_k_q     <= out_k_d;
      out_last_q  <= out_last_d;
      err_sop_q   <= err_sop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fa    = out_fa_q;
  assign out_fb    = out_fb_q;
  assign out_k     = out_k_q;
  assign out_last  = out_last_q;
  assign err_sop   = err_sop_q;

endmodule

`default_nettype wire

// File: tb/tb_dft_32to16_seq.sv
// ============================================================================
// Module : tb_dft_32to16_seq
// Brief  : Directed bench for dft_32to16_seq with hand-derived pair values.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dft_32to16_seq;

  typedef struct {
    int fa;
    int fb;
    int k;
    int last;
  } pair_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sop = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [8:0] out_fa;
  logic signed [8:0] out_fb;
  logic [3:0]        out_k;
  logic              out_last;
  logic              err_sop;
  logic              err_clr = 1'b0;

  int    vectors = 0;
  int    miscompares = 0;
  int    stall_cnt = 0;
  int    fr[32];
  pair_t exp_q[$];

  dft_32to16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fa    (out_fa),
    .out_fb    (out_fb),
    .out_k     (out_k),
    .out_last  (out_last),
    .err_sop   (err_sop),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int fa, input int fb, input int k);
    pair_t p;
    p.fa = fa;
    p.fb = fb;
    p.k = k;
    p.last = (k == 15) ? 1 : 0;
    exp_q.push_back(p);
  endtask

  // Output monitor: every emitted pair must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && in_valid && !in_ready) stall_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", int'(out_k), -1);
      end else begin
        pair_t p;
        p = exp_q.pop_front();
        chk("pair_fa", int'(out_fa), p.fa);
        chk("pair_fb", int'(out_fb), p.fb);
        chk("pair_k", int'(out_k), p.k);
        chk("pair_last", int'(out_last), p.last);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the sample is accepted.
  task automatic drive_sample(input int d, input bit sop);
    bit done;
    in_valid = 1'b1;
    in_sop = sop;
    in_data = 8'(d);
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("in_ready_timeout", 0, 1);
    in_sop = 1'b0;
  endtask

  task automatic send_frame(input int s[32], input int n_send, input int hold_k);
    for (int i = 0; i < n_send; i++) begin
      if (hold_k >= 0 && i == 16 + hold_k + 1) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_sop = 1'b0;
        in_data = 8'(s[i]);
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk("hold_in_ready", int'(in_ready), 0);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_k", int'(out_k), hold_k);
          chk("hold_fa", int'(out_fa), 2 * hold_k + 16);
          chk("hold_fb", int'(out_fb), -16);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      drive_sample(s[i], i == 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_fa", int'(out_fa), 0);
    chk("rst_out_fb", int'(out_fb), 0);
    chk("rst_out_k", int'(out_k), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_err_sop", int'(err_sop), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Ramp frame: fa = 2k+16, fb = -16.
    for (int n = 0; n < 32; n++) fr[n] = n;
    for (int k = 0; k < 16; k++) push(2 * k + 16, -16, k);
    send_frame(fr, 32, -1);
    idle_cycles(4);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_err_sop", int'(err_sop), 0);

    // Extremes.
    for (int n = 0; n < 32; n++) fr[n] = (n < 16) ? 127 : -128;
    for (int k = 0; k < 16; k++) push(-1, 255, k);
    send_frame(fr, 32, -1);
    for (int n = 0; n < 32; n++) fr[n] = (n < 16) ? -128 : 127;
    for (int k = 0; k < 16; k++) push(-1, -255, k);
    send_frame(fr, 32, -1);
    idle_cycles(4);
    chk("t2_drained", exp_q.size(), 0);

    // Back-to-back: ramp then x=3n-40 (fa = 6k-32, fb = -48), no gaps.
    stall_cnt = 0;
    for (int n = 0; n < 32; n++) fr[n] = n;
    for (int k = 0; k < 16; k++) push(2 * k + 16, -16, k);
    send_frame(fr, 32, -1);
    for (int n = 0; n < 32; n++) fr[n] = 3 * n - 40;
    for (int k = 0; k < 16; k++) push(6 * k - 32, -48, k);
    send_frame(fr, 32, -1);
    chk("t3_no_stall", stall_cnt, 0);
    idle_cycles(4);
    chk("t3_drained", exp_q.size(), 0);

    // Backpressure at k=5.
    for (int n = 0; n < 32; n++) fr[n] = n;
    for (int k = 0; k < 16; k++) push(2 * k + 16, -16, k);
    send_frame(fr, 32, 5);
    idle_cycles(4);
    chk("t4_drained", exp_q.size(), 0);

    // Early restart at sample 10; clean frame x=100-6n (fa = 104-12k, fb = 96).
    send_frame(fr, 10, -1);
    chk("t5_err_before", int'(err_sop), 0);
    for (int n = 0; n < 32; n++) fr[n] = 100 - 6 * n;
    for (int k = 0; k < 16; k++) push(104 - 12 * k, 96, k);
    send_frame(fr, 32, -1);
    idle_cycles(4);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_err_set", int'(err_sop), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", int'(err_sop), 0);

    // Missing in_sop in IDLE, then set-wins-over-clear.
    @(posedge clk);
    #1;
    drive_sample(7, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_missing_sop", int'(err_sop), 1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    drive_sample(9, 1'b0);
    in_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_set_wins", int'(err_sop), 1);
    chk("t5_no_output", int'(out_valid), 0);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;

    // Reset during PAIR at k=7.
    for (int n = 0; n < 32; n++) fr[n] = n;
    for (int k = 0; k < 7; k++) push(2 * k + 16, -16, k);
    send_frame(fr, 24, -1);
    in_valid = 1'b0;
    chk("t6_pending_k7", int'(out_k), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_k", int'(out_k), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 32; n++) fr[n] = -n;
    for (int k = 0; k < 16; k++) push(-(2 * k + 16), 16, k);
    send_frame(fr, 32, -1);
    idle_cycles(4);
    chk("t6_after_reset_drained", exp_q.size(), 0);
    chk("t6_err_sop", int'(err_sop), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
